seg_framebuf: RTL and testbench

SEG_FRAMEBUF -- requirements
Module: seg_framebuf

---
 rtl/seg_framebuf.sv | 247 ++++++++++++++++++++++++
 tb/tb_seg_framebuf.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_framebuf.sv
// -----------------------------------------------------------------------------
// seg_framebuf
//
// Segmented frame buffer for a rotating (persistence-of-vision style) display.
// The host writes and reads pixel words addressed by (segment, word offset).
// A scan engine streams all words of one segment per seg_tick. A segment
// pointer follows the rotation and is forced to 0 by the index pulse.
//
// Configuration macro: SEG_FRAMEBUF_DOUBLE_BUF_EN
//   defined   : two banks. The host writes one bank while the other is scanned.
//               swap_req arms a bank swap, which happens when a scan of
//               segment 0 starts.
//   undefined : one bank shared by the host and the scan engine. swap_req is
//               ignored and swap_pending is tied to 0.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   wr_en, rd_en             host write / read strobes
//   seg_select, word_offset  host address (out-of-range writes are ignored;
//                            out-of-range reads return 0)
//   d_in                     host write data
//   d_out, d_valid           host read data, one cycle after rd_en
//   index                    once-per-revolution pulse (segment 0 position)
//   seg_tick                 start scan-out of the next segment
//   scan_data, scan_valid    scanned pixel words
//   scan_last                flags the last word of a segment
//   swap_req, swap_pending   bank swap request / armed flag
//   overrun                  sticky: seg_tick arrived while a scan was running
// -----------------------------------------------------------------------------
module seg_framebuf #(
    parameter int  DATA_W     = 8,
    parameter int  SEG_COUNT  = 128,
    parameter int  WORD_COUNT = 256,
    localparam int SEG_W      = (SEG_COUNT  > 1) ? $clog2(SEG_COUNT)  : 1,
    localparam int WORD_W     = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [SEG_W-1:0]  seg_select,
    input  logic [WORD_W-1:0] word_offset,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic              d_valid,
    input  logic              index,
    input  logic              seg_tick,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,
    output logic              scan_last,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              overrun
);

    localparam int SEG_WORDS = SEG_COUNT * WORD_COUNT;
    localparam int LIN_W     = (SEG_WORDS > 1) ? $clog2(SEG_WORDS) : 1;
`ifdef SEG_FRAMEBUF_DOUBLE_BUF_EN
    localparam int MEM_AW    = LIN_W + 1;
    localparam int DEPTH     = 2 * SEG_WORDS;
`else
    localparam int MEM_AW    = LIN_W;
    localparam int DEPTH     = SEG_WORDS;
`endif

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Linear word address inside one bank.
    function automatic logic [LIN_W-1:0] lin_addr(input logic [SEG_W-1:0]  s,
                                                  input logic [WORD_W-1:0] w);
        return LIN_W'(s) * LIN_W'(WORD_COUNT) + LIN_W'(w);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
    logic [SEG_W-1:0]    scan_seg_q, scan_seg_d;
    logic [SEG_W-1:0]    seg_ptr_q, seg_ptr_d;
    logic                overrun_q, overrun_d;
    logic                scan_valid_q, scan_valid_d;
    logic                scan_last_q, scan_last_d;
    logic                d_valid_q;
    logic                rd_oor_q;

    logic [DATA_W-1:0]   mem [0:DEPTH-1];
    logic [DATA_W-1:0]   rd_word_q;
    logic [DATA_W-1:0]   scan_word_q;

    logic                host_in_range;
    logic                host_wr;
    logic                host_rd;
    logic [MEM_AW-1:0]   host_addr;
    logic [MEM_AW-1:0]   scan_addr;
    logic [SEG_W-1:0]    tick_seg;
    logic [SEG_W-1:0]    scan_seg_cur;
    logic [WORD_W-1:0]   scan_word_idx;
    logic                scan_issue;

    assign host_in_range = (32'(seg_select)  < 32'(SEG_COUNT)) &&
                           (32'(word_offset) < 32'(WORD_COUNT));
    assign host_wr       = wr_en & host_in_range;
    // A simultaneous write wins; the read is dropped.
    assign host_rd       = rd_en & ~wr_en;

    // Segment that a seg_tick in this cycle would scan.
    assign tick_seg      = index ? '0 : seg_ptr_q;

    // ------------------------------------------------------------------
    // Bank selection
    // ------------------------------------------------------------------
`ifdef SEG_FRAMEBUF_DOUBLE_BUF_EN
    // bank_q is the scan bank; the host always owns the other one.
    logic bank_q, bank_d;
    logic swap_pending_q, swap_pending_d;
    logic swap_now;

    assign swap_now       = seg_tick && (tick_seg == '0) && swap_pending_q;
    assign bank_d         = bank_q ^ swap_now;
    // Extra requests while armed are absorbed by the OR.
    assign swap_pending_d = swap_now ? 1'b0 : (swap_pending_q | swap_req);

    // The scan that triggers the swap already reads from the new bank.
    assign host_addr = {~bank_q, lin_addr(seg_select, word_offset)};
    assign scan_addr = {bank_d, lin_addr(scan_seg_cur, scan_word_idx)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q         <= 1'b0;
            swap_pending_q <= 1'b0;
        end else begin
            bank_q         <= bank_d;
            swap_pending_q <= swap_pending_d;
        end
    end

    assign swap_pending = swap_pending_q;
`else
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
    assign host_addr       = lin_addr(seg_select, word_offset);
    assign scan_addr       = lin_addr(scan_seg_cur, scan_word_idx);
    assign swap_pending    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Pixel memory: one write port, two registered read ports. Reads
    // sample the old contents when the same word is written (read-first).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (host_wr) begin
            mem[host_addr] <= d_in;
        end
        if (host_rd && host_in_range) begin
            rd_word_q <= mem[host_addr];
        end
        if (scan_issue) begin
            scan_word_q <= mem[scan_addr];
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: next state and issue logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        scan_seg_d    = scan_seg_q;
        seg_ptr_d     = seg_ptr_q;
        overrun_d     = overrun_q;
        scan_valid_d  = 1'b0;
        scan_last_d   = 1'b0;
        scan_issue    = 1'b0;
        scan_word_idx = word_cnt_q;
        scan_seg_cur  = scan_seg_q;

        if (index) begin
            seg_ptr_d = '0;
        end

        if (seg_tick) begin
            // Start (or restart) a segment: word 0 is read at this edge.
            if (state_q == RUN) begin
                overrun_d = 1'b1;
            end
            seg_ptr_d     = (tick_seg == SEG_W'(SEG_COUNT - 1)) ? '0 : tick_seg + 1'b1;
            scan_seg_cur  = tick_seg;
            scan_seg_d    = tick_seg;
            scan_word_idx = '0;
            scan_issue    = 1'b1;
            scan_valid_d  = 1'b1;
            scan_last_d   = (WORD_COUNT == 1);
            if (WORD_COUNT > 1) begin
                state_d    = RUN;
                word_cnt_d = WORD_W'(1);
            end else begin
                state_d    = IDLE;
                word_cnt_d = '0;
            end
        end else if (state_q == RUN) begin
            scan_issue    = 1'b1;
            scan_valid_d  = 1'b1;
            scan_last_d   = (word_cnt_q == WORD_W'(WORD_COUNT - 1));
            if (scan_last_d) begin
                state_d    = IDLE;
                word_cnt_d = '0;
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            scan_seg_q   <= '0;
            seg_ptr_q    <= '0;
            overrun_q    <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_last_q  <= 1'b0;
            d_valid_q    <= 1'b0;
            rd_oor_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            scan_seg_q   <= scan_seg_d;
            seg_ptr_q    <= seg_ptr_d;
            overrun_q    <= overrun_d;
            scan_valid_q <= scan_valid_d;
            scan_last_q  <= scan_last_d;
            d_valid_q    <= host_rd;
            rd_oor_q     <= ~host_in_range;
        end
    end

    // Data outputs are forced to 0 whenever their qualifier is low, so they
    // follow the asynchronous reset even though the RAM registers do not.
    assign d_out      = (d_valid_q && !rd_oor_q) ? rd_word_q : '0;
    assign d_valid    = d_valid_q;
    assign scan_data  = scan_valid_q ? scan_word_q : '0;
    assign scan_valid = scan_valid_q;
    assign scan_last  = scan_last_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_seg_framebuf.sv
// -----------------------------------------------------------------------------
// tb_seg_framebuf
//
// Directed self-checking bench for seg_framebuf with default parameters.
// Inputs are driven on the falling clock edge and outputs are sampled there,
// half a cycle after the rising edge that updated them.
// SEG_FRAMEBUF_DOUBLE_BUF_EN selects the double-buffer variant of the tests.
// -----------------------------------------------------------------------------
module tb_seg_framebuf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [6:0] seg_select = '0;
    logic [7:0] word_offset = '0;
    logic [7:0] d_in = '0;
    logic [7:0] d_out;
    logic       d_valid;
    logic       index = 1'b0;
    logic       seg_tick = 1'b0;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic       scan_last;
    logic       swap_req = 1'b0;
    logic       swap_pending;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    seg_framebuf #(
        .DATA_W     (8),
        .SEG_COUNT  (128),
        .WORD_COUNT (256)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .seg_select   (seg_select),
        .word_offset  (word_offset),
        .d_in         (d_in),
        .d_out        (d_out),
        .d_valid      (d_valid),
        .index        (index),
        .seg_tick     (seg_tick),
        .scan_data    (scan_data),
        .scan_valid   (scan_valid),
        .scan_last    (scan_last),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (drive only) ----------------
    task automatic host_write(input logic [6:0] s, input logic [7:0] w, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; seg_select = s; word_offset = w; d_in = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Writes word w of segment s with (w & and_m) ^ xor_m.
    task automatic fill_seg(input logic [6:0] s, input logic [7:0] and_m, input logic [7:0] xor_m);
        logic [7:0] w8;
        for (int w = 0; w < 256; w++) begin
            @(negedge clk);
            w8 = 8'(w);
            wr_en = 1'b1; seg_select = s; word_offset = w8; d_in = (w8 & and_m) ^ xor_m;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Returns on the falling edge right after the tick was sampled,
    // where scan word 0 is already visible.
    task automatic pulse_tick(input logic with_index);
        @(negedge clk);
        seg_tick = 1'b1; index = with_index;
        @(negedge clk);
        seg_tick = 1'b0; index = 1'b0;
    endtask

    task automatic pulse_swap();
        @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (d_out !== 8'h00)      begin errors++; $display("FAIL reset_d_out: got %h expected 00", d_out); end
        checks++; if (d_valid !== 1'b0)     begin errors++; $display("FAIL reset_d_valid: got %b expected 0", d_valid); end
        checks++; if (scan_data !== 8'h00)  begin errors++; $display("FAIL reset_scan_data: got %h expected 00", scan_data); end
        checks++; if (scan_valid !== 1'b0)  begin errors++; $display("FAIL reset_scan_valid: got %b expected 0", scan_valid); end
        checks++; if (scan_last !== 1'b0)   begin errors++; $display("FAIL reset_scan_last: got %b expected 0", scan_last); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_swap_pending: got %b expected 0", swap_pending); end
        checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst_n = 1'b1;
        idle_cycles(2);
        $display("test_reset done");
    endtask

    task automatic test_host_rw();
        @(negedge clk);
        wr_en = 1'b1; seg_select = 7'h65; word_offset = 8'hca; d_in = 8'hb2;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL rw_valid: got %b expected 1", d_valid); end
        checks++; if (d_out !== 8'hb2)  begin errors++; $display("FAIL rw_data: got %h expected b2", d_out); end
        @(negedge clk);
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rw_valid_single: got %b expected 0", d_valid); end
        fill_seg(7'h67, 8'h00, 8'h00);
        @(negedge clk);
        rd_en = 1'b1; seg_select = 7'h67; word_offset = 8'hca;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL rw_zero_valid: got %b expected 1", d_valid); end
        checks++; if (d_out !== 8'h00)  begin errors++; $display("FAIL rw_zero_data: got %h expected 00", d_out); end
        $display("test_host_rw done");
    endtask

    task automatic test_collision();
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1; seg_select = 7'h0a; word_offset = 8'h14; d_in = 8'hd0;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL collide_valid: got %b expected 0", d_valid); end
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL collide_read_valid: got %b expected 1", d_valid); end
        checks++; if (d_out !== 8'hd0)  begin errors++; $display("FAIL collide_read_data: got %h expected d0", d_out); end
        $display("test_collision done");
    endtask

    // index, then four ticks 300 cycles apart: segments 0,1,2,3.
    // Segment 2 holds word = offset, segment 3 holds ~offset.
    task automatic test_scan_sequence();
        int nbad;
        int first_k;
        logic [7:0] bad_d, exp_bad_d;
        logic bad_v, bad_l;
        logic exp_v, exp_l;
        logic [7:0] exp_d;
        fill_seg(7'h02, 8'hff, 8'h00);
        fill_seg(7'h03, 8'hff, 8'hff);
`ifdef SEG_FRAMEBUF_DOUBLE_BUF_EN
        pulse_swap();
`endif
        @(negedge clk); index = 1'b1;
        @(negedge clk); index = 1'b0;
        for (int t = 0; t < 4; t++) begin
            pulse_tick(1'b0);
            nbad = 0; first_k = -1; bad_d = '0; bad_v = 1'b0; bad_l = 1'b0; exp_bad_d = '0;
            for (int k = 0; k < 299; k++) begin
                if (t >= 2) begin
                    exp_v = (k < 256);
                    exp_l = (k == 255);
                    exp_d = (k < 256) ? ((t == 2) ? 8'(k) : ~8'(k)) : 8'h00;
                    if (scan_valid !== exp_v || scan_data !== exp_d || scan_last !== exp_l) begin
                        if (nbad == 0) begin
                            first_k = k; bad_d = scan_data; bad_v = scan_valid; bad_l = scan_last; exp_bad_d = exp_d;
                        end
                        nbad++;
                    end
                end
                @(negedge clk);
            end
            if (t >= 2) begin
                checks++;
                if (nbad !== 0) begin
                    errors++;
                    $display("FAIL scan_seg%0d: %0d bad cycles, first at %0d got data=%h valid=%b last=%b expected data=%h",
                             t, nbad, first_k, bad_d, bad_v, bad_l, exp_bad_d);
                end
            end
            $display("scan tick %0d done", t);
        end
    endtask

    task automatic test_read_first();
        host_write(7'h00, 8'h05, 8'h77);
        pulse_tick(1'b1);
        for (int k = 0; k < 270; k++) begin
            if (k == 4) begin
                wr_en = 1'b1; seg_select = 7'h00; word_offset = 8'h05; d_in = 8'h88;
            end
            if (k == 5) begin
                wr_en = 1'b0;
                checks++; if (scan_data !== 8'h77) begin errors++; $display("FAIL read_first_scan: got %h expected 77", scan_data); end
            end
            @(negedge clk);
        end
        rd_en = 1'b1; seg_select = 7'h00; word_offset = 8'h05;
        @(negedge clk);
        rd_en = 1'b0;
        checks++; if (d_out !== 8'h88) begin errors++; $display("FAIL read_first_host: got %h expected 88", d_out); end
        $display("test_read_first done");
    endtask

    task automatic test_overrun();
        int nbad;
        int first_k;
        logic [7:0] bad_d, exp_d;
        logic exp_v, exp_l;
        fill_seg(7'h01, 8'hff, 8'h5a);
`ifdef SEG_FRAMEBUF_DOUBLE_BUF_EN
        pulse_swap();
`endif
        pulse_tick(1'b1);
        idle_cycles(9);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", overrun); end
        seg_tick = 1'b1;
        @(negedge clk);
        seg_tick = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        nbad = 0; first_k = -1; bad_d = '0;
        for (int k = 0; k < 270; k++) begin
            exp_v = (k < 256);
            exp_l = (k == 255);
            exp_d = (k < 256) ? (8'(k) ^ 8'h5a) : 8'h00;
            if (scan_valid !== exp_v || scan_data !== exp_d || scan_last !== exp_l) begin
                if (nbad == 0) begin first_k = k; bad_d = scan_data; end
                nbad++;
            end
            @(negedge clk);
        end
        checks++;
        if (nbad !== 0) begin
            errors++;
            $display("FAIL overrun_restart: %0d bad cycles, first at %0d got data=%h expected %h",
                     nbad, first_k, bad_d, 8'(first_k) ^ 8'h5a);
        end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        $display("test_overrun done");
    endtask

`ifdef SEG_FRAMEBUF_DOUBLE_BUF_EN
    task automatic test_swap();
        host_write(7'h00, 8'h00, 8'h11);
        host_write(7'h05, 8'h00, 8'h11);
        pulse_swap();
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL swap_arm1: got %b expected 1", swap_pending); end
        pulse_tick(1'b1);
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap_clear1: got %b expected 0", swap_pending); end
        checks++; if (scan_data !== 8'h11)   begin errors++; $display("FAIL swap_data1: got %h expected 11", scan_data); end
        idle_cycles(299);
        host_write(7'h00, 8'h00, 8'hcd);
        host_write(7'h05, 8'h00, 8'hcd);
        pulse_swap();
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL swap_arm2: got %b expected 1", swap_pending); end
        for (int t = 1; t < 5; t++) begin
            pulse_tick(1'b0);
            idle_cycles(299);
        end
        pulse_tick(1'b0);
        checks++; if (scan_data !== 8'h11)   begin errors++; $display("FAIL swap_old_seg5: got %h expected 11", scan_data); end
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("FAIL swap_still_pending: got %b expected 1", swap_pending); end
        idle_cycles(299);
        pulse_tick(1'b1);
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap_clear2: got %b expected 0", swap_pending); end
        checks++; if (scan_data !== 8'hcd)   begin errors++; $display("FAIL swap_new_data: got %h expected cd", scan_data); end
        idle_cycles(299);
        $display("test_swap done");
    endtask
`else
    task automatic test_swap();
        pulse_swap();
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap_ignored: got %b expected 0", swap_pending); end
        host_write(7'h00, 8'h00, 8'hcd);
        pulse_tick(1'b1);
        checks++; if (scan_data !== 8'hcd)   begin errors++; $display("FAIL swap_shared_data: got %h expected cd", scan_data); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL swap_still_zero: got %b expected 0", swap_pending); end
        idle_cycles(299);
        $display("test_swap done");
    endtask
`endif

    task automatic test_reset_mid_scan();
        int nvalid;
        pulse_tick(1'b0);
        idle_cycles(100);
        checks++; if (scan_valid !== 1'b1) begin errors++; $display("FAIL midscan_running: got %b expected 1", scan_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (scan_valid !== 1'b0)  begin errors++; $display("FAIL midscan_valid_drop: got %b expected 0", scan_valid); end
        checks++; if (scan_data !== 8'h00)  begin errors++; $display("FAIL midscan_data_drop: got %h expected 00", scan_data); end
        checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL midscan_overrun: got %b expected 0", overrun); end
        idle_cycles(2);
        rst_n = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (scan_valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid !== 0) begin errors++; $display("FAIL midscan_quiet: got %0d valid cycles expected 0", nvalid); end
        pulse_tick(1'b0);
        checks++; if (scan_valid !== 1'b1) begin errors++; $display("FAIL midscan_retick: got %b expected 1", scan_valid); end
        idle_cycles(260);
        $display("test_reset_mid_scan done");
    endtask

    initial begin
        test_reset();
        test_host_rw();
        test_collision();
        test_scan_sequence();
`ifndef SEG_FRAMEBUF_DOUBLE_BUF_EN
        test_read_first();
`endif
        test_overrun();
        test_swap();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
